// File: rtl/au_gray_counter_if.sv
// au_gray_counter_if: count/load control and result bus of the Gray counter.
//   master : drives en, ld, d;  observes q, qb, tc, wrap, ovf
//   slave  : the counter side
interface au_gray_counter_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             ld;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qb;
  logic             tc;
  logic             wrap;
  logic             ovf;

  modport master (output en, ld, d, input q, qb, tc, wrap, ovf);
  modport slave  (input en, ld, d, output q, qb, tc, wrap, ovf);
endinterface

// File: rtl/au_gray_counter.sv
// au_gray_counter: registered Gray-code counter.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset (q <= INIT)
//   bus  : slave side of au_gray_counter_if
//          en  count enable (incrementer carry-in), ld load d (priority over en)
//          q   Gray count, qb binary image of q, tc terminal count (q == 10..0)
//          wrap one-cycle pulse after q went 10..0 -> 0, ovf sticky wrap flag
// gray_inc: Gray incrementer with carry-in; ARCH picks one of three
// functionally identical structures.

module gray_inc #(
  parameter int WIDTH = 8,
  parameter int ARCH  = 0
) (
  input  logic [WIDTH-1:0] a,
  input  logic             ci,
  output logic [WIDTH-1:0] y
);
  localparam logic [WIDTH-1:0] MSB = WIDTH'(1) << (WIDTH - 1);

  if (ARCH == 1) begin : g_ripple
    // Direct Gray rule: even parity flips bit 0, odd parity flips the bit
    // above the lowest set bit (or the msb itself when it is the only one).
    always_comb begin
      logic found;
      y     = a;
      found = 1'b0;
      if (ci) begin
        if (!(^a)) begin
          y[0] = ~a[0];
        end else begin
          for (int i = 0; i < WIDTH - 1; i++) begin
            if (!found && a[i]) begin
              found  = 1'b1;
              y[i+1] = ~a[i+1];
            end
          end
          if (!found) y[WIDTH-1] = ~a[WIDTH-1];
        end
      end
    end
  end else if (ARCH == 2) begin : g_onehot
    // Same rule with the lowest set bit isolated arithmetically.
    logic [WIDTH-1:0] lsb;
    logic [WIDTH-1:0] flip;
    always_comb begin
      lsb  = a & (~a + WIDTH'(1));
      flip = (^a) ? ((lsb << 1) | (lsb & MSB)) : WIDTH'(1);
      y    = ci ? (a ^ flip) : a;
    end
  end else begin : g_binary
    // Round trip through binary: convert, add ci, convert back.
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
    always_comb begin
      b[WIDTH-1] = a[WIDTH-1];
      for (int i = WIDTH - 2; i >= 0; i--) b[i] = b[i+1] ^ a[i];
      s = b + WIDTH'(ci);
      y = s ^ (s >> 1);
    end
  end
endmodule

module au_gray_counter #(
  parameter int               WIDTH = 8,
  parameter int               ARCH  = 0,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic               clk,
  input  logic               rst,
  au_gray_counter_if.slave   bus
);
  localparam logic [WIDTH-1:0] TC_CODE = WIDTH'(1) << (WIDTH - 1);

  function automatic logic [WIDTH-1:0] g2b(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  localparam logic [WIDTH-1:0] INIT_BIN = g2b(INIT);

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] qb_q, qb_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  logic             ci;
  logic             tc;
  logic [WIDTH-1:0] inc_y;

  assign tc = (q_q == TC_CODE);
  // Hold is simply the incrementer with carry-in 0.
  assign ci = bus.en & ~bus.ld;

  gray_inc #(.WIDTH(WIDTH), .ARCH(ARCH)) u_inc (
    .a  (q_q),
    .ci (ci),
    .y  (inc_y)
  );

  always_comb begin
    q_d    = inc_y;
    wrap_d = ci & tc;
    ovf_d  = ovf_q | (ci & tc);
    if (bus.ld) begin
      q_d   = bus.d;
      ovf_d = 1'b0;
    end
    // Binary image taken from the next state so qb lands with q.
    qb_d = g2b(q_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q    <= INIT;
      qb_q   <= INIT_BIN;
      wrap_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      q_q    <= q_d;
      qb_q   <= qb_d;
      wrap_q <= wrap_d;
      ovf_q  <= ovf_d;
    end
  end

  assign bus.q    = q_q;
  assign bus.qb   = qb_q;
  assign bus.tc   = tc;
  assign bus.wrap = wrap_q;
  assign bus.ovf  = ovf_q;
endmodule
